// File: rtl/nn_pkg.sv
// Shared NN pipeline package: default pixel type, counter-width helper and
// the 2-input max used by the pooling lanes.
package nn_pkg;

  localparam int NN_DATA_W   = 8;
  localparam int NN_CHANNELS = 2;
  localparam int NN_PIX_W    = NN_CHANNELS * NN_DATA_W;
  // Operands are widened to this width before comparison.
  localparam int NN_MAX_W    = 32;

  // Packed pixel at the pipeline's default geometry; ch0 sits in the LSBs.
  typedef logic [NN_PIX_W-1:0] nn_pixel_t;

  // Bits needed for a counter running 0..n-1 (never less than 1).
  function automatic int nn_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Max of two pre-extended operands. The left operand wins on ties.
  function automatic logic [NN_MAX_W-1:0] nn_max(input logic [NN_MAX_W-1:0] a,
                                                 input logic [NN_MAX_W-1:0] b,
                                                 input logic is_signed);
    logic a_ge;
    if (is_signed) a_ge = ($signed(a) >= $signed(b));
    else           a_ge = (a >= b);
    return a_ge ? a : b;
  endfunction

endpackage

// File: rtl/pool_max_lane.sv
// One channel, 2-input max. The vertical-stage instance (CLAMP=1) also carries
// the fused ReLU clamp when MAXPOOL_FUSED_RELU_EN is defined.
module pool_max_lane
  import nn_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DATA_SIGNED = 0,
  parameter int CLAMP       = 0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

`ifdef MAXPOOL_FUSED_RELU_EN
  // Clamping only matters for signed data; unsigned values are never negative.
  localparam bit RELU_ON = (CLAMP != 0) && (DATA_SIGNED != 0);
`else
  localparam bit RELU_ON = (CLAMP != 0) && 1'b0;
`endif

  logic [NN_MAX_W-1:0] a_x, b_x, m_x;
  logic [DATA_W-1:0]   m;
  logic                unused_hi;

  // Widen per signedness, pick the max, then optionally clamp negatives to 0.
  always_comb begin
    a_x = {{(NN_MAX_W-DATA_W){(DATA_SIGNED != 0) && a[DATA_W-1]}}, a};
    b_x = {{(NN_MAX_W-DATA_W){(DATA_SIGNED != 0) && b[DATA_W-1]}}, b};
    m_x = nn_max(a_x, b_x, DATA_SIGNED != 0);
    m   = m_x[DATA_W-1:0];
    y   = (RELU_ON && m[DATA_W-1]) ? '0 : m;
  end

  // Upper bits are only sign/zero extension of the selected operand.
  assign unused_hi = ^m_x[NN_MAX_W-1:DATA_W];

endmodule

// File: rtl/maxpool2d_stream.sv
// 2x2 / stride-2 streaming max-pool over a raster-order pixel stream.
// Even columns park the pixel in h_hold, odd columns form the horizontal max;
// even rows store it in a half-width line buffer, odd rows combine it with
// the stored value and load the output register.
// Optional feature macro: MAXPOOL_FUSED_RELU_EN (clamps signed negatives to 0).
module maxpool2d_stream
  import nn_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CHANNELS    = 2,
  parameter int IN_W        = 6,
  parameter int IN_H        = 6,
  parameter int DATA_SIGNED = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sof,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHANNELS*DATA_W-1:0] out_data,
  output logic                       out_last,
  output logic                       frame_err
);

  localparam int PIX_W = CHANNELS * DATA_W;
  localparam int OW    = IN_W / 2;
  localparam int CW    = nn_cnt_w(IN_W);
  localparam int RW    = nn_cnt_w(IN_H);
  localparam int BW    = (CW > 1) ? CW - 1 : 1;

  if ((IN_W % 2) != 0 || (IN_H % 2) != 0) begin : g_bad_dims
    $error("maxpool2d_stream: IN_W and IN_H must both be even");
  end

  logic [CW-1:0]    col_q, col_d, cur_col;
  logic [RW-1:0]    row_q, row_d, cur_row;
  logic [PIX_W-1:0] h_hold_q, h_hold_d;
  logic [PIX_W-1:0] line_buf_q [OW];
  logic [PIX_W-1:0] line_buf_d [OW];
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             frame_err_q, frame_err_d;

  logic             accept;
  logic [BW-1:0]    lb_idx;
  logic [PIX_W-1:0] lb_rd, hmax, vmax;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign frame_err = frame_err_q;

  // in_sof pins the beat to (0,0); otherwise the counters place it.
  assign cur_col = in_sof ? '0 : col_q;
  assign cur_row = in_sof ? '0 : row_q;
  assign lb_idx  = BW'(cur_col >> 1);
  assign lb_rd   = line_buf_q[lb_idx];

  // Horizontal (left wins) and vertical (top wins) max per channel.
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
    pool_max_lane #(.DATA_W(DATA_W), .DATA_SIGNED(DATA_SIGNED), .CLAMP(0)) u_hmax (
      .a (h_hold_q[ch*DATA_W +: DATA_W]),
      .b (in_data [ch*DATA_W +: DATA_W]),
      .y (hmax    [ch*DATA_W +: DATA_W])
    );
    pool_max_lane #(.DATA_W(DATA_W), .DATA_SIGNED(DATA_SIGNED), .CLAMP(1)) u_vmax (
      .a (lb_rd[ch*DATA_W +: DATA_W]),
      .b (hmax [ch*DATA_W +: DATA_W]),
      .y (vmax [ch*DATA_W +: DATA_W])
    );
  end

  // Next-state: output drain/load, window accumulation and raster counters.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    h_hold_d    = h_hold_q;
    line_buf_d  = line_buf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    frame_err_d = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (accept) begin
      // A restart needs no explicit flush: every window of the new frame
      // rewrites h_hold and its line-buffer slot before reading them.
      if (in_sof && (col_q != '0 || row_q != '0)) frame_err_d = 1'b1;

      if (!cur_col[0]) begin
        h_hold_d = in_data;
      end else if (!cur_row[0]) begin
        line_buf_d[lb_idx] = hmax;
      end else begin
        // in_ready guarantees any previous result is gone or draining now.
        out_data_d  = vmax;
        out_valid_d = 1'b1;
        out_last_d  = (cur_col == CW'(IN_W-1)) && (cur_row == RW'(IN_H-1));
      end

      if (cur_col == CW'(IN_W-1)) begin
        col_d = '0;
        row_d = (cur_row == RW'(IN_H-1)) ? '0 : RW'(cur_row + 1'b1);
      end else begin
        col_d = CW'(cur_col + 1'b1);
        row_d = cur_row;
      end
    end
  end

  // Control and output state; reset drops any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Window storage is always written before it is read, so it is not reset.
  always_ff @(posedge clk) begin
    h_hold_q   <= h_hold_d;
    line_buf_q <= line_buf_d;
  end

endmodule

// File: tb/tb_maxpool2d_stream.sv
// Bench for maxpool2d_stream: a 4x4 single-channel unsigned instance driven by
// directed and random frames against a frame-array reference model, plus a
// 2x2 two-channel signed instance for the signed / fused-ReLU compare.
module tb_maxpool2d_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       in_valid = 1'b0, in_sof = 1'b0, in_ready;
  logic [7:0] in_data = '0, out_data;
  logic       out_valid, out_last, frame_err;
  logic       out_ready = 1'b1;

  logic        s_in_valid = 1'b0, s_in_sof = 1'b0, s_in_ready;
  logic [15:0] s_in_data = '0, s_out_data;
  logic        s_out_valid, s_out_last, s_frame_err;
  logic        s_out_ready = 1'b1;

  maxpool2d_stream #(.DATA_W(8), .CHANNELS(1), .IN_W(4), .IN_H(4), .DATA_SIGNED(0)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .frame_err(frame_err));

  maxpool2d_stream #(.DATA_W(8), .CHANNELS(2), .IN_W(2), .IN_H(2), .DATA_SIGNED(1)) u_dut_s (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_sof(s_in_sof),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_last(s_out_last), .frame_err(s_frame_err));

  int checks = 0, errors = 0;
  int rdy_mode = 0, cyc = 0, ferr_cnt = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Downstream ready pattern: 0 always, 1 one-in-three, 2 stalled, 3 random.
  always @(posedge clk) begin
    #1;
    cyc++;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 3 == 0);
      2:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference model: raster position, frame pixel array, 2x2 max per window.
  int         mcol = 0, mrow = 0;
  logic [7:0] pix [4][4];
  bit         exp_ferr = 0, exp_rise = 0;

  function automatic logic [7:0] mx4(input logic [7:0] a, b, c, d);
    int m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return 8'(m);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      mcol = 0; mrow = 0; exp_q.delete(); exp_ferr = 0; exp_rise = 0;
    end else begin
      chk("frame_err", frame_err, exp_ferr);
      if (frame_err) ferr_cnt++;
      if (exp_rise) chk("latency_valid", out_valid, 1);
      chk("in_ready", in_ready, !out_valid || out_ready);
      exp_ferr = 0; exp_rise = 0;
      if (out_valid && out_ready) begin
        chk("unexpected_out", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("out_data", out_data, e[7:0]);
          chk("out_last", out_last, e[8]);
        end
        got_q.push_back({out_last, out_data});
      end
      if (in_valid && in_ready) begin
        if (in_sof) begin
          if (mcol != 0 || mrow != 0) exp_ferr = 1;
          mcol = 0; mrow = 0;
        end
        pix[mrow][mcol] = in_data;
        if ((mrow % 2 == 1) && (mcol % 2 == 1)) begin
          exp_q.push_back({(mrow == 3 && mcol == 3),
                           mx4(pix[mrow-1][mcol-1], pix[mrow-1][mcol], pix[mrow][mcol-1], pix[mrow][mcol])});
          exp_rise = 1;
        end
        mcol++;
        if (mcol == 4) begin mcol = 0; mrow = (mrow + 1) % 4; end
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [7:0] d, input logic sof);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_sof = sof;
    @(negedge clk);
    while (!in_ready && n < 100) begin n++; @(negedge clk); end
    chk("accept_timeout", n < 100, 1);
    sync();
    in_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_sof = 1'b0;
    repeat (n) sync();
  endtask

  task automatic send_frame(input logic [7:0] base, input logic use_sof);
    for (int i = 0; i < 16; i++) send(8'(base + i), use_sof && i == 0);
  endtask

  task automatic chk_ramp(input string tag, input int first);
    logic [8:0] ramp [4];
    ramp = '{9'h005, 9'h007, 9'h00D, 9'h10F};
    for (int i = 0; i < 4; i++)
      chk(tag, (first + i < got_q.size()) ? 32'(got_q[first+i]) : 32'hDEAD, ramp[i]);
  endtask

  initial begin
    logic [15:0] sbeat [4];
    int f0;
    repeat (2) sync();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_s_out_valid", s_out_valid, 0);
    sync();

    // Ramp frame, ready always high.
    got_q.delete(); rdy_mode = 0;
    send_frame(8'd0, 1'b1); idle(4);
    chk("ramp_count", got_q.size(), 4);
    chk_ramp("ramp_out", 0);

    // Same frame under one-in-three backpressure.
    got_q.delete(); rdy_mode = 1;
    send_frame(8'd0, 1'b1); idle(10);
    chk("bp_count", got_q.size(), 4);
    chk_ramp("bp_out", 0);

    // Signed two-channel window: ch0 {-5,-3,-8,-1}, ch1 {4,-2,9,0}.
    sbeat = '{16'h04FB, 16'hFEFD, 16'h09F8, 16'h00FF};
    for (int i = 0; i < 4; i++) begin
      s_in_valid = 1'b1; s_in_sof = (i == 0); s_in_data = sbeat[i];
      sync();
    end
    s_in_valid = 1'b0; s_in_sof = 1'b0;
    @(negedge clk);
    chk("signed_valid", s_out_valid, 1);
`ifdef MAXPOOL_FUSED_RELU_EN
    chk("signed_data", s_out_data, 16'h0900);
`else
    chk("signed_data", s_out_data, 16'h09FF);
`endif
    chk("signed_last", s_out_last, 1);
    chk("signed_ferr", s_frame_err, 0);
    sync();

    // Mid-frame in_sof on beat 6, which starts a full ramp frame.
    got_q.delete(); rdy_mode = 0; f0 = ferr_cnt;
    for (int i = 0; i < 6; i++) send(8'(i), i == 0);
    send_frame(8'd0, 1'b1); idle(4);
    chk("sof_ferr_pulses", ferr_cnt - f0, 1);
    chk("sof_count", got_q.size(), 5);
    chk("sof_pending", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, 9'h005);
    chk_ramp("sof_out", 1);

    // Reset mid row 1 while an output is held.
    rdy_mode = 2; sync();
    for (int i = 0; i < 6; i++) send(8'(i), 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("held_before_rst", out_valid, 1);
    sync(); reset = 1'b1;
    sync(); reset = 1'b0;
    @(negedge clk);
    chk("rst_drops_out", out_valid, 0);
    got_q.delete(); rdy_mode = 0; sync();
    send_frame(8'd0, 1'b0); idle(4);
    chk("post_rst_count", got_q.size(), 4);
    chk_ramp("post_rst_out", 0);

    // Two back-to-back frames without in_sof.
    got_q.delete();
    send_frame(8'h20, 1'b0); send_frame(8'h40, 1'b0); idle(4);
    chk("b2b_count", got_q.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("b2b_last", (i < got_q.size()) ? 32'(got_q[i][8]) : 32'hDEAD, (i == 3 || i == 7));

    // Random data, random idles, random ready, one mid-frame restart.
    rdy_mode = 3;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        send(8'($urandom), (i == 0 && f % 2 == 1) || (f == 2 && i == 9));
      end
    end
    rdy_mode = 0; idle(8);
    chk("all_delivered", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
